seg7_scan_controller: RTL
=========================

// Module: seg7_scan_controller
// PURPOSE
//  Scan sequencer for the 8-digit multiplexed seven-segment display.
//  Keeps a 4-byte history of bytes from the UART receiver (o_rx_valid/o_rx_byte)
//  and time-shares the single binary-to-7-segment decoder across 8 digits.
//  Each digit gets a fixed on-slot, followed by an all-off blanking gap to suppress ghosting.
//  Runs entirely on i_clk; no derived clocks.
// PARAMETERS
//  CLK_FREQ      100000000  i_clk frequency, Hz
//  REFRESH_HZ    10000      per-digit slot rate; DIV = CLK_FREQ/REFRESH_HZ cycles (DIV>=2)
//  BLANK_CYCLES  100        all-anodes-off cycles between slots (>=1)
// PORTS
//  i_clk        in   1  system clock
//  i_rst        in   1  synchronous, active-high reset
//  i_rx_valid   in   1  1-cycle strobe: i_rx_byte is valid
//  i_rx_byte    in   8  received byte
//  i_clear      in   1  1-cycle strobe: zero the byte history
//  o_nibble     out  4  hex value for the decoder (digit currently lit)
//  o_anode      out  8  active-low digit enables; at most one bit low
//  o_digit_idx  out  3  index of the current/next digit slot
//  o_blank      out  1  1 while all anodes are off
// BEHAVIOUR
//  Reset values (all registered outputs):
//  - o_anode=8'hFF, o_nibble=0, o_digit_idx=0, o_blank=1.
//  - history=32'h0, byte_cnt=0, FSM=S_BLANK, cnt=0.
//  History (32b):
//  - On i_rx_valid, history <= {history[23:0], i_rx_byte}, visible next cycle.
//  - byte_cnt increments and saturates at 4.
//  - Digit k shows history[4k+3:4k]; digit 0 is the low nibble of the newest byte.
//  - i_clear zeroes history and byte_cnt.
//  - i_clear and i_rx_valid in the same cycle: clear wins, byte dropped.
//  FSM (single counter cnt):
//  - S_BLANK: anodes all 1, o_blank=1; counts 0..BLANK_CYCLES-1, then -> S_SHOW.
//    On that exit edge, o_nibble latches nibble[o_digit_idx].
//    o_anode[o_digit_idx] goes 0 and o_blank goes 0 on the same edge.
//  - S_SHOW: counts 0..DIV-1, then -> S_BLANK.
//    On that exit edge, anodes go to all 1 and o_digit_idx increments (7 wraps to 0).
//  - o_nibble is frozen for the whole slot. A byte arriving mid-slot shows at that
//    digit's next slot; worst-case latency is 8*(DIV+BLANK_CYCLES) cycles.
//  - Frame period is 8*(DIV+BLANK_CYCLES) cycles; every digit gets exactly DIV lit cycles.
//  - i_rst mid-slot: next cycle all outputs at reset values and the scan restarts at digit 0.
//  - i_rst has priority over i_rx_valid and i_clear.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//  - Digits 2*byte_cnt..7 are suppressed: their slot timing is unchanged, but the
//    anode stays 1 and o_blank stays 1 for that slot.
//  - After reset or clear (byte_cnt=0), the whole display stays dark.
//  LEADING_ZERO_BLANK_EN undefined:
//  - All 8 digits are always lit in their slots; unfilled history shows 0.
//  - byte_cnt logic may be omitted.
// TESTING  (CLK_FREQ=1000, REFRESH_HZ=100 -> DIV=10, BLANK_CYCLES=2)
//  1. Release reset, no bytes.
//     -> o_anode=FF for 2 cycles, then FE for 10, FF for 2, FD for 10, ...
//     -> After 96 cycles, digit 0 is lit again; o_nibble=0 throughout.
//  2. Send bytes 8'hA5, 8'h3C.
//     -> history=32'h0000A53C; slots 0..3 show C,3,5,A; slots 4..7 show 0.
//  3. Send 8'h7E while digit 0 is lit (slot cycle 4).
//     -> o_nibble holds its old value until slot end.
//     -> Digit 0 shows E and digit 1 shows 7 from the next frame.
//  4. Same cycle i_clear=1 and i_rx_valid=1 (byte 8'hFF).
//     -> history=0; no F shown on any digit in the following frame.
//  5. Assert i_rst during digit 5 slot.
//     -> Next cycle o_anode=FF, o_digit_idx=0, o_blank=1; history=0.
//     -> Digit 0 lights 2 cycles after reset is released.
//  6. LEADING_ZERO_BLANK_EN defined, send 1 byte 8'h42.
//     -> Only digits 0,1 light (2,4); slots 2..7 keep o_anode=FF with unchanged timing.
//     -> After i_clear, all slots dark.
//  Every cycle: assert $countones(~o_anode)<=1 and o_blank==(o_anode==8'hFF).

Source files
------------

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//
// Scan sequencer for an 8-digit multiplexed seven-segment display. It keeps the
// last four received bytes as a 32-bit history. It then time-shares one external
// binary-to-7-segment decoder across the eight digits. Each digit gets a fixed
// on-slot of DIV = CLK_FREQ/REFRESH_HZ cycles. Each on-slot is preceded by an
// all-anodes-off gap of BLANK_CYCLES cycles, which suppresses ghosting. All
// outputs are registered, and everything runs on i_clk.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   - only digits 0 .. 2*byte_cnt-1 are lit; the remaining slots keep
//               their timing but stay dark (anodes all off, o_blank high).
//   undefined - all eight digits are lit in their slots; unfilled history shows 0.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous, active-high reset (priority over everything)
//   i_rx_valid   1-cycle strobe, i_rx_byte is valid
//   i_rx_byte    received byte, shifted into the history
//   i_clear      1-cycle strobe, zero the history (wins over i_rx_valid)
//   o_nibble     hex value for the decoder, frozen for the whole slot
//   o_anode      active-low digit enables, at most one bit low
//   o_digit_idx  index of the current/next digit slot
//   o_blank      high while all anodes are off

module seg7_scan_controller #(
  parameter int unsigned CLK_FREQ     = 100000000,
  parameter int unsigned REFRESH_HZ   = 10000,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_byte,
  input  logic       i_clear,
  output logic [3:0] o_nibble,
  output logic [7:0] o_anode,
  output logic [2:0] o_digit_idx,
  output logic       o_blank
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned Div    = CLK_FREQ / REFRESH_HZ;
  localparam int unsigned CntMax = (Div > BLANK_CYCLES) ? Div : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] DivLast   = CntW'(Div - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q,     state_d;
  logic [CntW-1:0]  cnt_q,       cnt_d;
  logic [31:0]      history_q,   history_d;
  logic [3:0]       nibble_q,    nibble_d;
  logic [7:0]       anode_q,     anode_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic             blank_q,     blank_d;

  // Nibble and anode pattern for the digit whose slot is about to start.
  logic [3:0]       nibble_sel;
  logic [7:0]       anode_lit;
  logic             digit_on;

  // ---------------------------------------------------------------------------
  // Byte history
  // ---------------------------------------------------------------------------
  always_comb begin
    history_d = history_q;
    if (i_clear) begin
      history_d = '0;
    end else if (i_rx_valid) begin
      history_d = {history_q[23:0], i_rx_byte};
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Number of bytes received since reset/clear, saturating at 4.
  logic [2:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (i_clear) begin
      byte_cnt_d = '0;
    end else if (i_rx_valid && (byte_cnt_q != 3'd4)) begin
      byte_cnt_d = byte_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Digits at or above 2*byte_cnt hold no received data and stay dark.
  assign digit_on = ({1'b0, digit_idx_q} < {byte_cnt_q, 1'b0});
`else
  assign digit_on = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Digit selection
  // ---------------------------------------------------------------------------
  // Digit k shows history[4k+3:4k]; digit 0 is the low nibble of the newest byte.
  assign nibble_sel = history_q[{digit_idx_q, 2'b00} +: 4];
  assign anode_lit  = ~(8'h01 << digit_idx_q);

  // ---------------------------------------------------------------------------
  // Scan FSM next state
  // ---------------------------------------------------------------------------
  // One counter serves both phases. It is cleared on every phase change, so it
  // never runs past the longer of the two phase lengths.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    nibble_d    = nibble_q;
    anode_d     = anode_q;
    digit_idx_d = digit_idx_q;
    blank_d     = blank_q;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == BlankLast) begin
          state_d  = StShow;
          cnt_d    = '0;
          // Sampled once here so the decoder input is stable for the whole slot.
          nibble_d = nibble_sel;
          if (digit_on) begin
            anode_d = anode_lit;
            blank_d = 1'b0;
          end
        end
      end
      StShow: begin
        if (cnt_q == DivLast) begin
          state_d     = StBlank;
          cnt_d       = '0;
          anode_d     = '1;
          blank_d     = 1'b1;
          digit_idx_d = digit_idx_q + 3'd1;
        end
      end
      default: begin
        state_d = StBlank;
        cnt_d   = '0;
        anode_d = '1;
        blank_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StBlank;
      cnt_q       <= '0;
      history_q   <= '0;
      nibble_q    <= '0;
      anode_q     <= '1;
      digit_idx_q <= '0;
      blank_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      history_q   <= history_d;
      nibble_q    <= nibble_d;
      anode_q     <= anode_d;
      digit_idx_q <= digit_idx_d;
      blank_q     <= blank_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_nibble    = nibble_q;
  assign o_anode     = anode_q;
  assign o_digit_idx = digit_idx_q;
  assign o_blank     = blank_q;

endmodule
